// File: rtl/thunderbird_pkg.sv
// Shared types for the parametrised Thunderbird tail-light controller.
// Purely declarative: no logic, no latency, no flow control.
package thunderbird_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_e;

  // idx must hold 0..n_lamps; clamp to 1 bit so an illegal N still elaborates far enough to report.
  function automatic int idx_width(input int n_lamps);
    return (n_lamps < 1) ? 1 : $clog2(n_lamps + 1);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: tick is high for one cycle out of every TICK_DIV (constantly high for TICK_DIV=1).
// Latency: tick is a decode of the counter, first high TICK_DIV-1 edges after reset; no backpressure.
module step_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'((TICK_DIV > 1) ? TICK_DIV - 1 : 0);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("step_prescaler: TICK_DIV must be >= 1 (got %0d)", TICK_DIV);
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // For TICK_DIV=1 LAST is 0 and the counter never leaves 0, so tick stays high.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/thunderbird_lights_param.sv
// Thunderbird tail lights: N_LAMPS-per-side sequential turn animation plus hazard flash, one step per tick.
// Latency: Moore, outputs registered and updated on the tick edge that samples the request; no backpressure.
module thunderbird_lights_param
  import thunderbird_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  output logic [N_LAMPS-1:0] l_lamps,
  output logic [N_LAMPS-1:0] r_lamps,
  output logic               active
);

  localparam int IW = idx_width(N_LAMPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_LAMPS);

  if (N_LAMPS < 1) begin : g_bad_lamps
    $error("thunderbird_lights_param: N_LAMPS must be >= 1 (got %0d)", N_LAMPS);
  end

  logic tick;

  step_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_LAMPS-1:0] l_lamps_q, l_lamps_d;
  logic [N_LAMPS-1:0] r_lamps_q, r_lamps_d;
  logic               active_q, active_d;
  logic [N_LAMPS-1:0] therm;
  logic               haz;

  assign haz = hazard | (left & right);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (haz) begin
            state_d = HAZ;
          end else if (left) begin
            state_d = LEFT;
            idx_d   = IW'(1);
          end else if (right) begin
            state_d = RIGHT;
            idx_d   = IW'(1);
          end
        end
        // Mid-sequence the opposite turn input is ignored, so only the hazard switch can preempt.
        LEFT, RIGHT: begin
          if (hazard) begin
            state_d = HAZ;
            idx_d   = '0;
          end else if (idx_q < LAST_IDX) begin
            idx_d = idx_q + IW'(1);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        HAZ: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode is done on the next state so the registered lamps line up with the state flop.
  always_comb begin
    therm = '0;
    for (int i = 0; i < N_LAMPS; i++) begin
      therm[i] = (int'(idx_d) > i);
    end
  end

  always_comb begin
    l_lamps_d = '0;
    r_lamps_d = '0;
    unique case (state_d)
      LEFT:    l_lamps_d = therm;
      RIGHT:   r_lamps_d = therm;
      HAZ: begin
        l_lamps_d = '1;
        r_lamps_d = '1;
      end
      default: begin
        l_lamps_d = '0;
        r_lamps_d = '0;
      end
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      l_lamps_q <= '0;
      r_lamps_q <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      l_lamps_q <= l_lamps_d;
      r_lamps_q <= r_lamps_d;
      active_q  <= active_d;
    end
  end

  assign l_lamps = l_lamps_q;
  assign r_lamps = r_lamps_q;
  assign active  = active_q;

endmodule

// File: tb/tb_thunderbird_lights_param.sv
// Directed bench for thunderbird_lights_param: a 3-lamp/div-1 instance and a 4-lamp/div-4 instance.
// Expected lamp patterns are queued as each step is driven and compared after the following edge.
module tb_thunderbird_lights_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a = 1'b1, left_a = 1'b0, right_a = 1'b0, hazard_a = 1'b0;
  logic [2:0] l_a, r_a;
  logic       act_a;

  logic       reset_b = 1'b1, left_b = 1'b0, right_b = 1'b0, hazard_b = 1'b0;
  logic [3:0] l_b, r_b;
  logic       act_b;

  thunderbird_lights_param #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .left    (left_a),
    .right   (right_a),
    .hazard  (hazard_a),
    .l_lamps (l_a),
    .r_lamps (r_a),
    .active  (act_a)
  );

  thunderbird_lights_param #(.N_LAMPS(4), .TICK_DIV(4)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .left    (left_b),
    .right   (right_b),
    .hazard  (hazard_b),
    .l_lamps (l_b),
    .r_lamps (r_b),
    .active  (act_b)
  );

  typedef struct packed {
    logic       sel;
    logic [3:0] l;
    logic [3:0] r;
    logic       a;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Queue the expectation for the coming edge, then compare the chosen instance just after it.
  task automatic step(input logic sel, input logic [3:0] l, input logic [3:0] r,
                      input logic a, input string name);
    exp_t  e;
    exp_t  got;
    string n;
    e.sel = sel;
    e.l   = l;
    e.r   = r;
    e.a   = a;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e       = exp_q.pop_front();
    n       = name_q.pop_front();
    got.sel = e.sel;
    if (e.sel) begin
      got.l = l_b;
      got.r = r_b;
      got.a = act_b;
    end else begin
      got.l = {1'b0, l_a};
      got.r = {1'b0, r_a};
      got.a = act_a;
    end
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed l=%b r=%b active=%b, expected l=%b r=%b active=%b",
             n, got.l, got.r, got.a, e.l, e.r, e.a);
    end
  endtask

  logic [3:0] b_pat [0:4];

  initial begin
    b_pat[0] = 4'b0001;
    b_pat[1] = 4'b0011;
    b_pat[2] = 4'b0111;
    b_pat[3] = 4'b1111;
    b_pat[4] = 4'b0000;

    // Reset state
    step(SEL_A, 4'b000, 4'b000, 1'b0, "a_reset");
    reset_a = 1'b0;

    // Held left: 001,011,111,000 repeating
    left_a = 1'b1;
    step(SEL_A, 4'b001, 4'b000, 1'b1, "left_hold_1");
    step(SEL_A, 4'b011, 4'b000, 1'b1, "left_hold_2");
    step(SEL_A, 4'b111, 4'b000, 1'b1, "left_hold_3");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "left_hold_4");
    step(SEL_A, 4'b001, 4'b000, 1'b1, "left_hold_5");
    step(SEL_A, 4'b011, 4'b000, 1'b1, "left_hold_6");
    step(SEL_A, 4'b111, 4'b000, 1'b1, "left_hold_7");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "left_hold_8");
    left_a = 1'b0;

    // Right sequence; left joins at step 2 and is ignored until IDLE
    right_a = 1'b1;
    step(SEL_A, 4'b000, 4'b001, 1'b1, "right_1");
    left_a = 1'b1;
    step(SEL_A, 4'b000, 4'b011, 1'b1, "right_2_left_ign");
    step(SEL_A, 4'b000, 4'b111, 1'b1, "right_3_left_ign");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "right_done");
    left_a  = 1'b0;
    right_a = 1'b0;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "idle_after_right");

    // left & right from IDLE behaves as hazard
    left_a  = 1'b1;
    right_a = 1'b1;
    step(SEL_A, 4'b111, 4'b111, 1'b1, "lr_haz_on_1");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "lr_haz_off_1");
    step(SEL_A, 4'b111, 4'b111, 1'b1, "lr_haz_on_2");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "lr_haz_off_2");
    left_a  = 1'b0;
    right_a = 1'b0;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "idle_after_lr");

    // Hazard switch alone
    hazard_a = 1'b1;
    step(SEL_A, 4'b111, 4'b111, 1'b1, "haz_on_1");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "haz_off_1");
    step(SEL_A, 4'b111, 4'b111, 1'b1, "haz_on_2");
    hazard_a = 1'b0;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "haz_released");

    // Hazard preempts a left sequence at a step boundary, then left resumes
    left_a = 1'b1;
    step(SEL_A, 4'b001, 4'b000, 1'b1, "pre_1");
    step(SEL_A, 4'b011, 4'b000, 1'b1, "pre_2");
    hazard_a = 1'b1;
    step(SEL_A, 4'b111, 4'b111, 1'b1, "pre_haz");
    hazard_a = 1'b0;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "pre_off");
    step(SEL_A, 4'b001, 4'b000, 1'b1, "pre_resume");
    // Releasing left mid-sequence does not abort it
    left_a = 1'b0;
    step(SEL_A, 4'b011, 4'b000, 1'b1, "release_2");
    step(SEL_A, 4'b111, 4'b000, 1'b1, "release_3");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "release_done");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "release_idle");

    // Reset mid-sequence, then restart from idx 1
    left_a = 1'b1;
    step(SEL_A, 4'b001, 4'b000, 1'b1, "rst_seq_1");
    step(SEL_A, 4'b011, 4'b000, 1'b1, "rst_seq_2");
    reset_a = 1'b1;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "rst_mid_seq");
    reset_a = 1'b0;
    step(SEL_A, 4'b001, 4'b000, 1'b1, "rst_restart");
    left_a = 1'b0;
    step(SEL_A, 4'b011, 4'b000, 1'b1, "rst_restart_2");
    step(SEL_A, 4'b111, 4'b000, 1'b1, "rst_restart_3");
    step(SEL_A, 4'b000, 4'b000, 1'b0, "rst_restart_done");

    // Reset mid-hazard
    hazard_a = 1'b1;
    step(SEL_A, 4'b111, 4'b111, 1'b1, "rst_haz_on");
    reset_a = 1'b1;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "rst_mid_haz");
    reset_a  = 1'b0;
    hazard_a = 1'b0;
    step(SEL_A, 4'b000, 4'b000, 1'b0, "rst_haz_idle");

    // 4 lamps, 4 cycles per step: restart prescaler, then a 2-cycle pulse between ticks
    reset_b = 1'b1;
    step(SEL_B, 4'b0000, 4'b0000, 1'b0, "b_reset");
    reset_b = 1'b0;
    left_b  = 1'b1;
    step(SEL_B, 4'b0000, 4'b0000, 1'b0, "b_pulse_1");
    step(SEL_B, 4'b0000, 4'b0000, 1'b0, "b_pulse_2");
    left_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(SEL_B, 4'b0000, 4'b0000, 1'b0, $sformatf("b_pulse_lost_%0d", k));
    end

    // Held left: three cycles before the next tick, then each pattern for exactly 4 cycles
    left_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(SEL_B, 4'b0000, 4'b0000, 1'b0, $sformatf("b_wait_tick_%0d", k));
    end
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) begin
        step(SEL_B, b_pat[p], 4'b0000, (b_pat[p] != 4'b0000),
             $sformatf("b_step%0d_cyc%0d", p, k));
      end
    end
    left_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
